// File: rtl/axi_write_burst_source.sv
// Burst sequencer plus show-ahead write FIFO feeding the AXI write data channel engine.
// Optional completed-burst counter enabled by defining WRITE_BURST_STATS_EN.
module axi_write_burst_source #(
   parameter int data_width = 32,
   parameter int fifo_depth = 8,
   parameter int len_width  = 8
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic [len_width-1:0]          req_len,
   input  logic [3:0]                    req_id,
   input  logic [data_width-1:0]         wr_data,
   input  logic                          wr_valid,
   output logic                          wr_ready,
   output logic [data_width-1:0]         data,
   output logic                          data_valid,
   output logic                          go,
   output logic                          last_transfer,
   output logic [3:0]                    transaction_ID,
   input  logic                          data_sent,
   input  logic                          done,
   output logic                          busy,
   output logic [$clog2(fifo_depth):0]   fifo_level,
   output logic [15:0]                   burst_count
);

   localparam int aw = $clog2(fifo_depth);
   localparam logic [len_width:0] beat_one   = (len_width+1)'(1);
   localparam logic [aw-1:0]      ptr_one    = aw'(1);
   localparam logic [aw:0]        level_one  = (aw+1)'(1);
   localparam logic [aw:0]        level_full = (aw+1)'(fifo_depth);

   typedef enum logic [1:0] {IDLE, STREAM, WAIT_DONE, RELEASE} state_t;

   state_t                state_q, state_d;
   logic [len_width:0]    beats_left_q, beats_left_d;
   logic [3:0]            tid_q, tid_d;
   logic [aw-1:0]         wr_ptr_q, rd_ptr_q;
   logic [aw:0]           level_q;
   logic [data_width-1:0] mem [fifo_depth];

   logic fifo_full, fifo_empty, push, pop;

   assign fifo_full  = (level_q == level_full);
   assign fifo_empty = (level_q == '0);
   assign push       = wr_valid && !fifo_full;

   // NOTE: every signal driven here gets a default before the case statement,
   // so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d       = state_q;
      beats_left_d  = beats_left_q;
      tid_d         = tid_q;
      req_ready     = 1'b0;
      go            = 1'b0;
      data_valid    = 1'b0;
      last_transfer = 1'b0;
      pop           = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               tid_d        = req_id;
               beats_left_d = {1'b0, req_len} + beat_one;
               state_d      = STREAM;
            end
         end
         STREAM: begin
            go            = 1'b1;
            data_valid    = !fifo_empty;
            last_transfer = (beats_left_q == beat_one);
            // A beat only retires when there is a word to hand over.
            pop           = data_sent && !fifo_empty;
            if (pop) begin
               beats_left_d = beats_left_q - beat_one;
               if (beats_left_q == beat_one) state_d = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            go = 1'b1;
            if (done) state_d = RELEASE;
         end
         RELEASE: begin
            if (!done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= IDLE;
         beats_left_q <= '0;
         tid_q        <= '0;
      end else begin
         state_q      <= state_d;
         beats_left_q <= beats_left_d;
         tid_q        <= tid_d;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + ptr_one;
         if (pop)  rd_ptr_q <= rd_ptr_q + ptr_one;
         case ({push, pop})
            2'b10:   level_q <= level_q + level_one;
            2'b01:   level_q <= level_q - level_one;
            default: level_q <= level_q;
         endcase
      end
   end

   // NOTE: the storage array is deliberately left out of reset; the pointers
   // and level define validity, and the output mux hides stale contents.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= wr_data;
   end

   assign data           = data_valid ? mem[rd_ptr_q] : '0;
   assign wr_ready       = !fifo_full;
   assign busy           = (state_q != IDLE);
   assign transaction_ID = tid_q;
   assign fifo_level     = level_q;

`ifdef WRITE_BURST_STATS_EN
   logic [15:0] burst_count_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         burst_count_q <= '0;
      end else if (state_q == WAIT_DONE && done) begin
         burst_count_q <= burst_count_q + 16'd1;
      end
   end

   assign burst_count = burst_count_q;
`else
   assign burst_count = '0;
`endif

endmodule

// File: tb/tb_axi_write_burst_source.sv
// Directed bench for axi_write_burst_source: a cycle table for the basic bursts,
// then hand-written sequences for FIFO fill/wrap and mid-burst reset.
module tb_axi_write_burst_source;

`ifdef WRITE_BURST_STATS_EN
   localparam bit stats_en = 1'b1;
`else
   localparam bit stats_en = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        resetn;
   logic        req_valid;
   logic        req_ready;
   logic [7:0]  req_len;
   logic [3:0]  req_id;
   logic [31:0] wr_data;
   logic        wr_valid;
   logic        wr_ready;
   logic [31:0] data;
   logic        data_valid;
   logic        go;
   logic        last_transfer;
   logic [3:0]  transaction_ID;
   logic        data_sent;
   logic        done;
   logic        busy;
   logic [3:0]  fifo_level;
   logic [15:0] burst_count;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   axi_write_burst_source #(
      .data_width(32), .fifo_depth(8), .len_width(8)
   ) dut (
      .clk(clk), .resetn(resetn),
      .req_valid(req_valid), .req_ready(req_ready), .req_len(req_len), .req_id(req_id),
      .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .data(data), .data_valid(data_valid), .go(go), .last_transfer(last_transfer),
      .transaction_ID(transaction_ID), .data_sent(data_sent), .done(done),
      .busy(busy), .fifo_level(fifo_level), .burst_count(burst_count)
   );

   typedef struct {
      logic        req_valid;
      logic [7:0]  req_len;
      logic [3:0]  req_id;
      logic        wr_valid;
      logic [31:0] wr_data;
      logic        data_sent;
      logic        done;
      logic        e_req_ready;
      logic        e_wr_ready;
      logic        e_go;
      logic        e_dv;
      logic        e_lt;
      logic [31:0] e_data;
      logic [3:0]  e_tid;
      logic        e_busy;
      logic [3:0]  e_level;
      logic [15:0] e_bc;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t v(
      input logic rv, input logic [7:0] len, input logic [3:0] id, input logic wv,
      input logic [31:0] wd, input logic ds, input logic dn,
      input logic rr, input logic wr, input logic g, input logic dv, input logic lt,
      input logic [31:0] d, input logic [3:0] tid, input logic b, input logic [3:0] lvl,
      input logic [15:0] bc);
      vec_t r;
      r.req_valid = rv; r.req_len = len; r.req_id = id; r.wr_valid = wv;
      r.wr_data = wd; r.data_sent = ds; r.done = dn;
      r.e_req_ready = rr; r.e_wr_ready = wr; r.e_go = g; r.e_dv = dv; r.e_lt = lt;
      r.e_data = d; r.e_tid = tid; r.e_busy = b; r.e_level = lvl;
      r.e_bc = stats_en ? bc : 16'd0;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Closes a burst from WAIT_DONE: done held three cycles, then released.
   task automatic finish_burst(input string tag, input logic [15:0] exp_bc);
      @(negedge clk);
      check({tag, " wait go"}, 32'(go), 32'd1);
      check({tag, " wait dv"}, 32'(data_valid), 32'd0);
      done = 1'b1;
      step();
      @(negedge clk);
      check({tag, " release go"}, 32'(go), 32'd0);
      check({tag, " release req_ready"}, 32'(req_ready), 32'd0);
      check({tag, " burst_count"}, 32'(burst_count), 32'(stats_en ? exp_bc : 16'd0));
      step();
      step();
      done = 1'b0;
      @(negedge clk);
      check({tag, " req_ready after done low"}, 32'(req_ready), 32'd0);
      step();
      @(negedge clk);
      check({tag, " idle req_ready"}, 32'(req_ready), 32'd1);
      check({tag, " idle busy"}, 32'(busy), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic sampled_ready;
      logic [3:0] exp_lvl;

      resetn = 1'b0; req_valid = 1'b0; req_len = '0; req_id = '0;
      wr_data = '0; wr_valid = 1'b0; data_sent = 1'b0; done = 1'b0;

      // {req_valid,len,id,wr_valid,wr_data,ds,done | req_ready,wr_ready,go,dv,lt,data,tid,busy,level,bc}
      vecs.push_back(v(0,0,0,1,32'hA0,0,0, 1,1,0,0,0,32'h00,0,0,0,0));
      vecs.push_back(v(0,0,0,1,32'hA1,0,0, 1,1,0,0,0,32'h00,0,0,1,0));
      vecs.push_back(v(0,0,0,1,32'hA2,0,0, 1,1,0,0,0,32'h00,0,0,2,0));
      vecs.push_back(v(0,0,0,1,32'hA3,0,0, 1,1,0,0,0,32'h00,0,0,3,0));
      vecs.push_back(v(1,3,5,0,32'h00,1,0, 1,1,0,0,0,32'h00,0,0,4,0));
      vecs.push_back(v(0,0,0,0,32'h00,1,0, 0,1,1,1,0,32'hA0,5,1,4,0));
      vecs.push_back(v(0,0,0,0,32'h00,1,0, 0,1,1,1,0,32'hA1,5,1,3,0));
      vecs.push_back(v(0,0,0,0,32'h00,1,0, 0,1,1,1,0,32'hA2,5,1,2,0));
      vecs.push_back(v(0,0,0,0,32'h00,1,0, 0,1,1,1,1,32'hA3,5,1,1,0));
      vecs.push_back(v(0,0,0,0,32'h00,1,0, 0,1,1,0,0,32'h00,5,1,0,0));
      vecs.push_back(v(0,0,0,0,32'h00,0,1, 0,1,1,0,0,32'h00,5,1,0,0));
      vecs.push_back(v(0,0,0,0,32'h00,0,1, 0,1,0,0,0,32'h00,5,1,0,1));
      vecs.push_back(v(0,0,0,0,32'h00,0,1, 0,1,0,0,0,32'h00,5,1,0,1));
      vecs.push_back(v(0,0,0,0,32'h00,0,0, 0,1,0,0,0,32'h00,5,1,0,1));
      vecs.push_back(v(1,0,9,0,32'h00,0,0, 1,1,0,0,0,32'h00,5,0,0,1));
      vecs.push_back(v(0,0,0,0,32'h00,1,0, 0,1,1,0,1,32'h00,9,1,0,1));
      vecs.push_back(v(0,0,0,0,32'h00,1,0, 0,1,1,0,1,32'h00,9,1,0,1));
      vecs.push_back(v(0,0,0,1,32'h11,1,0, 0,1,1,0,1,32'h00,9,1,0,1));
      vecs.push_back(v(0,0,0,0,32'h00,1,0, 0,1,1,1,1,32'h11,9,1,1,1));
      vecs.push_back(v(0,0,0,0,32'h00,0,1, 0,1,1,0,0,32'h00,9,1,0,1));
      vecs.push_back(v(0,0,0,0,32'h00,0,0, 0,1,0,0,0,32'h00,9,1,0,2));
      vecs.push_back(v(0,0,0,0,32'h00,0,0, 1,1,0,0,0,32'h00,9,0,0,2));

      // Reset values while reset is held.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst req_ready", 32'(req_ready), 32'd1);
      check("rst wr_ready", 32'(wr_ready), 32'd1);
      check("rst go", 32'(go), 32'd0);
      check("rst data_valid", 32'(data_valid), 32'd0);
      check("rst last_transfer", 32'(last_transfer), 32'd0);
      check("rst tid", 32'(transaction_ID), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst level", 32'(fifo_level), 32'd0);
      check("rst burst_count", 32'(burst_count), 32'd0);
      check("rst data", data, 32'd0);
      resetn = 1'b1;
      step();

      foreach (vecs[i]) begin
         req_valid = vecs[i].req_valid; req_len = vecs[i].req_len; req_id = vecs[i].req_id;
         wr_valid = vecs[i].wr_valid; wr_data = vecs[i].wr_data;
         data_sent = vecs[i].data_sent; done = vecs[i].done;
         @(negedge clk);
         check($sformatf("row%0d req_ready", i), 32'(req_ready), 32'(vecs[i].e_req_ready));
         check($sformatf("row%0d wr_ready", i), 32'(wr_ready), 32'(vecs[i].e_wr_ready));
         check($sformatf("row%0d go", i), 32'(go), 32'(vecs[i].e_go));
         check($sformatf("row%0d data_valid", i), 32'(data_valid), 32'(vecs[i].e_dv));
         check($sformatf("row%0d last_transfer", i), 32'(last_transfer), 32'(vecs[i].e_lt));
         check($sformatf("row%0d data", i), data, vecs[i].e_data);
         check($sformatf("row%0d tid", i), 32'(transaction_ID), 32'(vecs[i].e_tid));
         check($sformatf("row%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
         check($sformatf("row%0d level", i), 32'(fifo_level), 32'(vecs[i].e_level));
         check($sformatf("row%0d burst_count", i), 32'(burst_count), 32'(vecs[i].e_bc));
         step();
      end
      req_valid = 1'b0; wr_valid = 1'b0; data_sent = 1'b0; done = 1'b0;

      // Fill the FIFO without a request; the ninth word must be held off.
      for (int i = 0; i < 8; i++) begin
         wr_valid = 1'b1;
         wr_data  = 32'hB0 + 32'(i);
         @(negedge clk);
         check($sformatf("fill%0d wr_ready", i), 32'(wr_ready), 32'd1);
         check($sformatf("fill%0d level", i), 32'(fifo_level), 32'(i));
         step();
      end
      wr_data = 32'hB8;
      @(negedge clk);
      check("full wr_ready", 32'(wr_ready), 32'd0);
      check("full level", 32'(fifo_level), 32'd8);
      step();
      req_valid = 1'b1; req_len = 8'd8; req_id = 4'd3;
      @(negedge clk);
      check("full level held", 32'(fifo_level), 32'd8);
      check("full req_ready", 32'(req_ready), 32'd1);
      step();
      req_valid = 1'b0;
      data_sent = 1'b1;
      for (int i = 0; i < 9; i++) begin
         exp_lvl = (i == 0) ? 4'd8 : (i == 1) ? 4'd7 : 4'(9 - i);
         @(negedge clk);
         check($sformatf("wrap%0d dv", i), 32'(data_valid), 32'd1);
         check($sformatf("wrap%0d data", i), data, 32'hB0 + 32'(i));
         check($sformatf("wrap%0d level", i), 32'(fifo_level), 32'(exp_lvl));
         check($sformatf("wrap%0d last", i), 32'(last_transfer), 32'(i == 8));
         check($sformatf("wrap%0d tid", i), 32'(transaction_ID), 32'd3);
         sampled_ready = wr_ready;
         step();
         if (wr_valid && sampled_ready) wr_valid = 1'b0;
      end
      data_sent = 1'b0;
      check("wrap held word accepted", 32'(wr_valid), 32'd0);
      finish_burst("burst3", 16'd3);

      // Reset in the middle of a four-beat burst, after two beats.
      for (int i = 0; i < 4; i++) begin
         wr_valid = 1'b1;
         wr_data  = 32'hC0 + 32'(i);
         step();
      end
      wr_valid = 1'b0;
      req_valid = 1'b1; req_len = 8'd3; req_id = 4'd2;
      step();
      req_valid = 1'b0;
      data_sent = 1'b1;
      @(negedge clk);
      check("mid beat0 data", data, 32'hC0);
      @(negedge clk);
      check("mid beat1 data", data, 32'hC1);
      check("mid beat1 level", 32'(fifo_level), 32'd3);
      @(posedge clk);
      #2;
      resetn = 1'b0;
      data_sent = 1'b0;
      #1;
      check("async rst go", 32'(go), 32'd0);
      check("async rst dv", 32'(data_valid), 32'd0);
      check("async rst level", 32'(fifo_level), 32'd0);
      check("async rst busy", 32'(busy), 32'd0);
      check("async rst req_ready", 32'(req_ready), 32'd1);
      check("async rst tid", 32'(transaction_ID), 32'd0);
      check("async rst burst_count", 32'(burst_count), 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      step();

      // Clean single-beat burst after reset.
      wr_valid = 1'b1; wr_data = 32'hD0;
      req_valid = 1'b1; req_len = 8'd0; req_id = 4'd7;
      step();
      wr_valid = 1'b0; req_valid = 1'b0;
      @(negedge clk);
      check("post go", 32'(go), 32'd1);
      check("post dv", 32'(data_valid), 32'd1);
      check("post data", data, 32'hD0);
      check("post last", 32'(last_transfer), 32'd1);
      check("post tid", 32'(transaction_ID), 32'd7);
      check("post level", 32'(fifo_level), 32'd1);
      data_sent = 1'b1;
      step();
      data_sent = 1'b0;
      finish_burst("post", 16'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
